// File: rtl/bc_sched_if.sv
// Handshake bundle between the motion scheduler, its two command sources and the PWM stage.
// The slave modport is the scheduler's view; master is the surrounding system's view.
interface bc_sched_if #(
    parameter int DATA_W = 16
);
    logic [DATA_W-1:0] prog_data;
    logic              prog_valid;
    logic              prog_rdy;
    logic [DATA_W-1:0] avoid_data;
    logic              avoid_valid;
    logic              avoid_rdy;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_rdy;

    modport master (
        output prog_data, prog_valid, avoid_data, avoid_valid, out_rdy,
        input  prog_rdy, avoid_rdy, out_data, out_valid
    );

    modport slave (
        input  prog_data, prog_valid, avoid_data, avoid_valid, out_rdy,
        output prog_rdy, avoid_rdy, out_data, out_valid
    );
endinterface

// File: rtl/bc_sched.sv
// Command scheduler: plays program commands with a fixed hold time and lets obstacle-avoidance
// commands pre-empt them. Optional accepted-avoid counter is enabled by BC_SCHED_OVR_CNT_EN.
module bc_sched #(
    parameter int DATA_W      = 16,
    parameter int HOLD_CYCLES = 1650,
    parameter int OVR_TIMEOUT = 3300
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    bc_sched_if.slave    bus,
    output logic         pc_inc,
    output logic         ovr_active
`ifdef BC_SCHED_OVR_CNT_EN
    ,
    output logic [7:0]   ovr_count
`endif
);

    localparam int CNT_MAX = (HOLD_CYCLES > OVR_TIMEOUT) ? HOLD_CYCLES : OVR_TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        PROG_ISSUE,
        PROG_SEND,
        PROG_HOLD,
        OVR_SEND,
        OVR_HOLD
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [DATA_W-1:0]  r_out_data;
    logic               r_out_valid;
    logic               r_pc_inc;
    logic               r_ovr_active;

    logic               w_avoid_rdy;
    logic               w_prog_rdy;
    logic               w_avoid_acc;
    logic               w_prog_acc;
    logic               w_out_hs;
    logic               w_cnt_zero;

    // Avoid only needs the output register free; program additionally yields to a waiting avoid.
    assign w_avoid_rdy = en & ~r_out_valid;
    assign w_prog_rdy  = en & (r_state == PROG_ISSUE) & ~bus.avoid_valid;
    assign w_avoid_acc = w_avoid_rdy & bus.avoid_valid;
    assign w_prog_acc  = w_prog_rdy & bus.prog_valid;
    assign w_out_hs    = r_out_valid & bus.out_rdy;
    assign w_cnt_zero  = (r_cnt == '0);

    assign bus.avoid_rdy = w_avoid_rdy;
    assign bus.prog_rdy  = w_prog_rdy;
    assign bus.out_data  = r_out_data;
    assign bus.out_valid = r_out_valid;
    assign pc_inc        = r_pc_inc;
    assign ovr_active    = r_ovr_active;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= PROG_ISSUE;
            r_cnt        <= '0;
            r_out_data   <= '0;
            r_out_valid  <= 1'b0;
            r_pc_inc     <= 1'b0;
            r_ovr_active <= 1'b0;
        end else begin
            r_pc_inc <= 1'b0;

            // A pending output always completes, even with the scheduler disabled.
            if (w_out_hs) begin
                r_out_valid <= 1'b0;
            end

            if (w_avoid_acc) begin
                r_out_data   <= bus.avoid_data;
                r_out_valid  <= 1'b1;
                r_state      <= OVR_SEND;
                r_ovr_active <= 1'b1;
            end else if (w_prog_acc) begin
                r_out_data   <= bus.prog_data;
                r_out_valid  <= 1'b1;
                r_state      <= PROG_SEND;
            end else begin
                case (r_state)
                    // Send-to-hold moves with the handshake, not with en, so a
                    // handshake finished while disabled cannot strand the FSM.
                    PROG_SEND: begin
                        if (w_out_hs) begin
                            r_state <= PROG_HOLD;
                            r_cnt   <= CNT_W'(HOLD_CYCLES - 1);
                        end
                    end
                    OVR_SEND: begin
                        if (w_out_hs) begin
                            r_state <= OVR_HOLD;
                            r_cnt   <= CNT_W'(OVR_TIMEOUT - 1);
                        end
                    end
                    PROG_HOLD: begin
                        if (en) begin
                            if (w_cnt_zero) begin
                                r_pc_inc <= 1'b1;
                                r_state  <= PROG_ISSUE;
                            end else begin
                                r_cnt <= r_cnt - 1'b1;
                            end
                        end
                    end
                    OVR_HOLD: begin
                        if (en) begin
                            if (w_cnt_zero) begin
                                r_state      <= PROG_ISSUE;
                                r_ovr_active <= 1'b0;
                            end else begin
                                r_cnt <= r_cnt - 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef BC_SCHED_OVR_CNT_EN
    logic [7:0] r_ovr_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ovr_count <= 8'd0;
        end else if (w_avoid_acc && (r_ovr_count != 8'hFF)) begin
            r_ovr_count <= r_ovr_count + 8'd1;
        end
    end

    assign ovr_count = r_ovr_count;
`endif

endmodule

// File: doc/bc_sched.md
BC_SCHED -- requirements
Module: bc_sched

Interface
REQ-001 SHALL have parameter DATA_W, default 16, command word width.
REQ-002 SHALL have parameter HOLD_CYCLES, default 1650, cycles each program command is held before advancing; legal range >=1.
REQ-003 SHALL have parameter OVR_TIMEOUT, default 3300, idle cycles after the last avoid command before program resumes; legal range >=1.
REQ-004 SHALL have port clk, input, 1, the single clock; all state on rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port en, input, 1, scheduler enable.
REQ-007 SHALL have port prog_data, input, DATA_W, program command from block memory.
REQ-008 SHALL have port prog_valid, input, 1, prog_data valid.
REQ-009 SHALL have port prog_rdy, output, 1, program command accepted this cycle when high with prog_valid.
REQ-010 SHALL have port avoid_data, input, DATA_W, obstacle-avoidance override command.
REQ-011 SHALL have port avoid_valid, input, 1, avoid_data valid.
REQ-012 SHALL have port avoid_rdy, output, 1, avoid command accepted when high with avoid_valid.
REQ-013 SHALL have port out_data, output, DATA_W, registered command to the PWM stage.
REQ-014 SHALL have port out_valid, output, 1, out_data valid.
REQ-015 SHALL have port out_rdy, input, 1, PWM stage accepts out_data.
REQ-016 SHALL have port pc_inc, output, 1, one-cycle pulse advancing the program counter.
REQ-017 SHALL have port ovr_active, output, 1, high in OVR_SEND and OVR_HOLD.

Function
REQ-018 SHALL implement states PROG_ISSUE, PROG_SEND, PROG_HOLD, OVR_SEND, OVR_HOLD.
REQ-019 SHALL drive avoid_rdy = en & ~out_valid in every state; avoid has strict priority over program.
REQ-020 SHALL drive prog_rdy = en & state==PROG_ISSUE & ~avoid_valid; simultaneous valids -> avoid accepted, prog not.
REQ-021 SHALL, on an accepted word, load out_data and set out_valid on the next cycle (latency 1); out_data stable while out_valid & ~out_rdy.
REQ-022 SHALL clear out_valid the cycle after out_valid & out_rdy; never drop out_valid before acceptance, including when en falls.
REQ-023 SHALL transition: program accept -> PROG_SEND; avoid accept (any state) -> OVR_SEND.
REQ-024 SHALL, on out handshake in PROG_SEND, enter PROG_HOLD with hold counter = HOLD_CYCLES-1; decrement each cycle while en is high.
REQ-025 SHALL, in PROG_HOLD at counter 0 with no avoid accept, pulse pc_inc high for exactly one cycle and enter PROG_ISSUE.
REQ-026 SHALL, on avoid accept during PROG_HOLD, abort the hold with no pc_inc, so the same program command is reissued later.
REQ-027 SHALL, on out handshake in OVR_SEND, enter OVR_HOLD with timeout counter = OVR_TIMEOUT-1; each further avoid accept reloads it via OVR_SEND.
REQ-028 SHALL, in OVR_HOLD at counter 0 with no avoid accept, enter PROG_ISSUE without pc_inc.
REQ-029 SHALL, when en is low, freeze counters and state except completion of a pending out handshake; pc_inc stays low.
REQ-030 SHALL size counters to $clog2(max(HOLD_CYCLES,OVR_TIMEOUT)+1) bits, unsigned, no wrap below 0.

Reset
REQ-031 SHALL, while rst is low, force state PROG_ISSUE, counters 0, out_data 0, out_valid 0, pc_inc 0, ovr_active 0, asynchronously, including mid-handshake.
REQ-032 SHALL leave reset synchronously on the first rising clk after rst rises; prog_rdy/avoid_rdy are combinational and follow REQ-019/020 from then on.

Configuration
REQ-033 SHALL, with BC_SCHED_OVR_CNT_EN defined, add output ovr_count[7:0] counting accepted avoid commands, saturating at 255, reset to 0.
REQ-034 SHALL, without BC_SCHED_OVR_CNT_EN, omit ovr_count and its logic; all other behaviour identical.

Verification
REQ-035 SHALL cover: HOLD_CYCLES=4, prog_data=0x1234 valid, out_rdy=1 -> out_data=0x1234 one cycle after accept, pc_inc pulse exactly 4 cycles after out handshake.
REQ-036 SHALL cover: prog_valid and avoid_valid both high in PROG_ISSUE with 0xAAAA/0x5555 -> only avoid_rdy high, out_data=0x5555, ovr_active=1.
REQ-037 SHALL cover: avoid 0x00FF arrives mid PROG_HOLD, OVR_TIMEOUT=3 -> no pc_inc; PROG_ISSUE re-entered 3 cycles after the avoid out handshake, same program word reissued.
REQ-038 SHALL cover: out_rdy held low 10 cycles with out_valid high -> out_data stable, avoid_rdy and prog_rdy low throughout.
REQ-039 SHALL cover: rst low mid PROG_SEND -> out_valid=0, out_data=0, pc_inc=0 immediately without clk edge; after release prog_rdy=1.
REQ-040 SHALL cover: with BC_SCHED_OVR_CNT_EN, 300 accepted avoid commands -> ovr_count=255.
